// File: rtl/stk_pipe_mem_tail_tbl.sv
// Tail-pointer table for the stk pipe: independent read/write ports over one 1rw SRAM,
// using a one-entry write buffer with read forwarding and a post-reset clear sequencer.

module generic_sram_1rw #(
  parameter int W = 10,
  parameter int N = 1024,
  parameter int A = $clog2(N)
) (
  input  logic         clk,
  input  logic         en,
  input  logic         we,
  input  logic [A-1:0] addr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      else    dout      <= mem[addr];
    end
  end

endmodule

module stk_pipe_mem_tail_tbl #(
  parameter int             W        = 10,
  parameter int             N        = 1024,
  parameter int             A        = $clog2(N),
  parameter logic [W-1:0]   INIT_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_rd_vld,
  input  logic [A-1:0] i_rd_addr,
  output logic         o_rd_vld,
  output logic [W-1:0] o_rd_data,
  input  logic         i_wr_vld,
  input  logic [A-1:0] i_wr_addr,
  input  logic [W-1:0] i_wr_data,
  output logic         o_wr_rdy,
  output logic         o_busy
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t       state;
  logic [A-1:0] cnt;
  logic         run;
  logic         wr_acc;

  logic         wb_vld;
  logic [A-1:0] wb_addr;
  logic [W-1:0] wb_data;

  logic         sram_en;
  logic         sram_we;
  logic [A-1:0] sram_addr;
  logic [W-1:0] sram_din;
  logic [W-1:0] sram_dout;

  logic         fwd_p0;
  logic         vld_p1;
  logic         fwd_p1;
  logic [W-1:0] fwd_data_p1;
  logic [W-1:0] rd_data_hold;
  logic [W-1:0] rd_data_mux;

  assign run      = (state == S_RUN) && !rst;
  assign o_busy   = (state == S_INIT);
  assign o_wr_rdy = run && !(wb_vld && i_rd_vld);
  assign wr_acc   = i_wr_vld && o_wr_rdy;
  assign fwd_p0   = wb_vld && (wb_addr == i_rd_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      case (state)
        S_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == A'(N - 1)) state <= S_RUN;
        end
        default: state <= S_RUN;
      endcase
    end
  end

  // Single SRAM port: init clear, then read > buffer drain > direct write.
  always_comb begin
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    sram_addr = i_rd_addr;
    sram_din  = i_wr_data;
    if (state == S_INIT) begin
      sram_en   = 1'b1;
      sram_we   = 1'b1;
      sram_addr = cnt;
      sram_din  = INIT_VAL;
    end else if (run) begin
      if (i_rd_vld) begin
        sram_en   = 1'b1;
        sram_addr = i_rd_addr;
      end else if (wb_vld) begin
        sram_en   = 1'b1;
        sram_we   = 1'b1;
        sram_addr = wb_addr;
        sram_din  = wb_data;
      end else if (wr_acc) begin
        sram_en   = 1'b1;
        sram_we   = 1'b1;
        sram_addr = i_wr_addr;
        sram_din  = i_wr_data;
      end
    end
  end

  generic_sram_1rw #(.W(W), .N(N), .A(A)) u_sram (
    .clk  (clk),
    .en   (sram_en),
    .we   (sram_we),
    .addr (sram_addr),
    .din  (sram_din),
    .dout (sram_dout)
  );

  // A write lands in the buffer when a read holds the port, or when the old
  // buffer entry drains this cycle; otherwise a buffer-empty write goes straight in.
  always_ff @(posedge clk) begin
    if (rst)       wb_vld <= 1'b0;
    else if (run)  wb_vld <= i_rd_vld ? (wb_vld || wr_acc) : (wb_vld && wr_acc);
  end

  always_ff @(posedge clk) begin
    if (wr_acc && (i_rd_vld || wb_vld)) begin
      wb_addr <= i_wr_addr;
      wb_data <= i_wr_data;
    end
  end

  // ---- p0 -> p1: read response stage
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= run && i_rd_vld;
  end

  always_ff @(posedge clk) begin
    fwd_p1      <= fwd_p0;
    fwd_data_p1 <= wb_data;
  end

  assign rd_data_mux = vld_p1 ? (fwd_p1 ? fwd_data_p1 : sram_dout) : rd_data_hold;

  always_ff @(posedge clk) begin
    if (rst)         rd_data_hold <= '0;
    else if (vld_p1) rd_data_hold <= rd_data_mux;
  end

  assign o_rd_vld  = vld_p1;
  assign o_rd_data = rd_data_mux;

endmodule

// File: tb/tb_stk_pipe_mem_tail_tbl.sv
// Directed and randomised checks of the tail table: a 16-entry instance for
// hand-computed scenarios and a 64-entry instance against a scoreboard.

module tb_stk_pipe_mem_tail_tbl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       a_rd_vld, a_wr_vld, a_o_rd_vld, a_wr_rdy, a_busy;
  logic [3:0] a_rd_addr, a_wr_addr;
  logic [9:0] a_wr_data, a_o_rd_data;

  logic       b_rd_vld, b_wr_vld, b_o_rd_vld, b_wr_rdy, b_busy;
  logic [5:0] b_rd_addr, b_wr_addr;
  logic [9:0] b_wr_data, b_o_rd_data;

  int total = 0;
  int bad   = 0;

  stk_pipe_mem_tail_tbl #(.W(10), .N(16)) u_dut16 (
    .clk(clk), .rst(rst),
    .i_rd_vld(a_rd_vld), .i_rd_addr(a_rd_addr),
    .o_rd_vld(a_o_rd_vld), .o_rd_data(a_o_rd_data),
    .i_wr_vld(a_wr_vld), .i_wr_addr(a_wr_addr), .i_wr_data(a_wr_data),
    .o_wr_rdy(a_wr_rdy), .o_busy(a_busy)
  );

  stk_pipe_mem_tail_tbl #(.W(10), .N(64)) u_dut64 (
    .clk(clk), .rst(rst),
    .i_rd_vld(b_rd_vld), .i_rd_addr(b_rd_addr),
    .o_rd_vld(b_o_rd_vld), .o_rd_data(b_o_rd_data),
    .i_wr_vld(b_wr_vld), .i_wr_addr(b_wr_addr), .i_wr_data(b_wr_data),
    .o_wr_rdy(b_wr_rdy), .o_busy(b_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic rv, input logic [3:0] ra,
                       input logic wv, input logic [3:0] wa, input logic [9:0] wd);
    a_rd_vld  = rv;
    a_rd_addr = ra;
    a_wr_vld  = wv;
    a_wr_addr = wa;
    a_wr_data = wd;
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1;
    drv_a(0, 0, 0, 0, 0);
    b_rd_vld = 0; b_rd_addr = 0; b_wr_vld = 0; b_wr_addr = 0; b_wr_data = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL rst_busy: got %b want 1", a_busy); end
    total++; if (a_o_rd_vld !== 1'b0) begin bad++; $display("FAIL rst_rd_vld: got %b want 0", a_o_rd_vld); end
    total++; if (a_wr_rdy !== 1'b0) begin bad++; $display("FAIL rst_wr_rdy: got %b want 0", a_wr_rdy); end
    total++; if (a_o_rd_data !== 10'h0) begin bad++; $display("FAIL rst_rd_data: got %h want 000", a_o_rd_data); end
    rst = 1'b0;
    n = 0;
    while (a_busy === 1'b1 && n < 100) begin
      total++; if (a_o_rd_vld !== 1'b0) begin bad++; $display("FAIL init_rd_vld: got %b want 0", a_o_rd_vld); end
      n++;
      tick();
    end
    total++; if (n != 16) begin bad++; $display("FAIL init_len: got %0d want 16", n); end
  endtask

  task automatic test_init_reads;
    for (int i = 0; i < 16; i++) begin
      drv_a(1, 4'(i), 0, 0, 0);
      tick();
      total++;
      if (a_o_rd_vld !== 1'b1 || a_o_rd_data !== 10'h0) begin
        bad++; $display("FAIL init_read[%0d]: got vld=%b data=%h want vld=1 data=000", i, a_o_rd_vld, a_o_rd_data);
      end
    end
    drv_a(0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_write_read;
    drv_a(0, 0, 1, 3, 10'h2A);
    #1;
    total++; if (a_wr_rdy !== 1'b1) begin bad++; $display("FAIL wr_rdy_idle: got %b want 1", a_wr_rdy); end
    tick();
    drv_a(1, 3, 0, 0, 0);
    tick();
    total++;
    if (a_o_rd_vld !== 1'b1 || a_o_rd_data !== 10'h2A) begin
      bad++; $display("FAIL wr_then_rd: got vld=%b data=%h want vld=1 data=02a", a_o_rd_vld, a_o_rd_data);
    end
    drv_a(0, 0, 0, 0, 0);
    tick();
    total++;
    if (a_o_rd_vld !== 1'b0 || a_o_rd_data !== 10'h2A) begin
      bad++; $display("FAIL rd_hold: got vld=%b data=%h want vld=0 data=02a", a_o_rd_vld, a_o_rd_data);
    end
  endtask

  task automatic test_forward;
    drv_a(1, 9, 1, 5, 10'h155);
    #1;
    total++; if (a_wr_rdy !== 1'b1) begin bad++; $display("FAIL fwd_wr_rdy: got %b want 1", a_wr_rdy); end
    tick();
    total++;
    if (a_o_rd_vld !== 1'b1 || a_o_rd_data !== 10'h0) begin
      bad++; $display("FAIL fwd_rd9: got vld=%b data=%h want vld=1 data=000", a_o_rd_vld, a_o_rd_data);
    end
    drv_a(1, 5, 0, 0, 0);
    tick();
    total++; if (a_o_rd_data !== 10'h155) begin bad++; $display("FAIL fwd_buf: got %h want 155", a_o_rd_data); end
    drv_a(0, 0, 0, 0, 0);
    tick();
    drv_a(1, 7, 1, 7, 10'h3FF);
    #1;
    total++; if (a_wr_rdy !== 1'b1) begin bad++; $display("FAIL rw_same_rdy: got %b want 1", a_wr_rdy); end
    tick();
    total++;
    if (a_o_rd_vld !== 1'b1 || a_o_rd_data !== 10'h0) begin
      bad++; $display("FAIL read_first: got vld=%b data=%h want vld=1 data=000", a_o_rd_vld, a_o_rd_data);
    end
    drv_a(1, 7, 0, 0, 0);
    tick();
    total++; if (a_o_rd_data !== 10'h3FF) begin bad++; $display("FAIL rw_same_later: got %h want 3ff", a_o_rd_data); end
    drv_a(1, 5, 0, 0, 0);
    tick();
    total++; if (a_o_rd_data !== 10'h155) begin bad++; $display("FAIL drained_5: got %h want 155", a_o_rd_data); end
    drv_a(0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_backpressure;
    drv_a(1, 0, 1, 10, 10'h0AA);
    tick();
    drv_a(1, 1, 1, 11, 10'h0BB);
    #1;
    total++; if (a_wr_rdy !== 1'b0) begin bad++; $display("FAIL bp_rdy_low: got %b want 0", a_wr_rdy); end
    tick();
    total++; if (a_o_rd_data !== 10'h0) begin bad++; $display("FAIL bp_rd1: got %h want 000", a_o_rd_data); end
    drv_a(0, 0, 1, 11, 10'h0BB);
    #1;
    total++; if (a_wr_rdy !== 1'b1) begin bad++; $display("FAIL bp_rdy_high: got %b want 1", a_wr_rdy); end
    tick();
    drv_a(0, 0, 0, 0, 0);
    tick();
    drv_a(1, 10, 0, 0, 0);
    tick();
    total++; if (a_o_rd_data !== 10'h0AA) begin bad++; $display("FAIL bp_rd10: got %h want 0aa", a_o_rd_data); end
    drv_a(1, 11, 0, 0, 0);
    tick();
    total++; if (a_o_rd_data !== 10'h0BB) begin bad++; $display("FAIL bp_rd11: got %h want 0bb", a_o_rd_data); end
    drv_a(0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset_midop;
    int n;
    drv_a(1, 4, 1, 2, 10'h011);
    tick();
    drv_a(1, 4, 0, 0, 0);
    rst = 1'b1;
    tick();
    total++; if (a_o_rd_vld !== 1'b0) begin bad++; $display("FAIL midrst_rd_vld: got %b want 0", a_o_rd_vld); end
    total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL midrst_busy: got %b want 1", a_busy); end
    drv_a(0, 0, 0, 0, 0);
    rst = 1'b0;
    n = 0;
    while (a_busy === 1'b1 && n < 100) begin n++; tick(); end
    total++; if (n != 16) begin bad++; $display("FAIL reinit_len: got %0d want 16", n); end
    drv_a(1, 2, 0, 0, 0);
    tick();
    total++;
    if (a_o_rd_vld !== 1'b1 || a_o_rd_data !== 10'h0) begin
      bad++; $display("FAIL midrst_rd2: got vld=%b data=%h want vld=1 data=000", a_o_rd_vld, a_o_rd_data);
    end
    drv_a(1, 3, 0, 0, 0);
    tick();
    total++; if (a_o_rd_data !== 10'h0) begin bad++; $display("FAIL midrst_rd3: got %h want 000", a_o_rd_data); end
    drv_a(0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_random;
    logic [9:0] mdl [64];
    logic       wb, exp_v, busy_m, rdy_m, acc, rv, wv;
    logic [9:0] exp_d, wd;
    logic [5:0] ra, wa;
    int         errs;
    for (int i = 0; i < 64; i++) mdl[i] = 10'h0;
    wb = 0; exp_v = 0; exp_d = 0; errs = 0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10000; k++) begin
      busy_m = (k < 64);
      total++;
      if (b_o_rd_vld !== exp_v || (exp_v && b_o_rd_data !== exp_d)) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rnd_rd[%0d]: got vld=%b data=%h want vld=%b data=%h", k, b_o_rd_vld, b_o_rd_data, exp_v, exp_d);
      end
      total++;
      if (b_busy !== busy_m) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rnd_busy[%0d]: got %b want %b", k, b_busy, busy_m);
      end
      rv = 1'($urandom_range(0, 1));
      wv = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
      wa = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
      wd = 10'($urandom);
      b_rd_vld = rv; b_rd_addr = ra; b_wr_vld = wv; b_wr_addr = wa; b_wr_data = wd;
      #1;
      rdy_m = !busy_m && !(wb && rv);
      total++;
      if (b_wr_rdy !== rdy_m) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rnd_rdy[%0d]: got %b want %b", k, b_wr_rdy, rdy_m);
      end
      exp_v = rv && !busy_m;
      exp_d = mdl[ra];
      acc   = wv && rdy_m;
      if (acc) mdl[wa] = wd;
      if (!busy_m) wb = rv ? (wb || acc) : (wb && acc);
      tick();
    end
    b_rd_vld = 0; b_wr_vld = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_init_reads();
    test_write_read();
    test_forward();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stk_pipe_mem_tail_tbl.md
Name: stk_pipe_mem_tail_tbl

Overview:
Parametrised tail-pointer table for the stack pipe. It presents independent read and write ports on top of a single 1rw SRAM (generic_sram_1rw) by means of a one-entry write buffer with read forwarding. After reset, a hardware sequencer clears every entry to INIT_VAL, so software-visible state is defined without any explicit flush. It sits in the stk pipe memory stage, replacing the fixed 10b x 1024 tail SRAM wrapper.

Parameters:
W, 10, data width (tail pointer bits)
N, 1024, number of entries (power of two, >=2)
A, $clog2(N), address width (derived; not overridden)
INIT_VAL, '0, value written to every entry by the init sequencer

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
i_rd_vld  input  1  read request
i_rd_addr  input  A  read address
o_rd_vld  output  1  read response valid, 1 cycle after request
o_rd_data  output  W  read response data
i_wr_vld  input  1  write request (taken when i_wr_vld & o_wr_rdy)
i_wr_addr  input  A  write address
i_wr_data  input  W  write data
o_wr_rdy  output  1  write accepted this cycle
o_busy  output  1  init sequencer active; all requests ignored

Behaviour:
- One clock, synchronous active-high reset.
- Reset values: o_rd_vld=0, o_rd_data=0, o_busy=1, o_wr_rdy=0; write buffer invalid; init counter=0.
- FSM states:
  - INIT: SRAM write addr=cnt, data=INIT_VAL; cnt++ each cycle; at cnt==N-1 go to RUN next cycle.
  - RUN: normal operation; o_busy=0.
- INIT lasts exactly N cycles after rst deasserts. Reads are ignored during INIT (no o_rd_vld). o_wr_rdy=0 during INIT.
- o_wr_rdy = RUN & ~(wb_vld & i_rd_vld). This is combinational from i_rd_vld; no dependence on i_wr_vld.
- Reads are always accepted in RUN. Latency 1: o_rd_vld asserts the cycle after i_rd_vld and holds for 1 cycle per request. Back-to-back reads are supported every cycle.
- SRAM port arbitration per RUN cycle (read has priority):
  - Read present: SRAM reads i_rd_addr. An accepted write loads the buffer (buffer was empty, by o_wr_rdy).
  - No read, wb_vld: SRAM writes the buffer contents. An accepted write reloads the buffer in the same cycle; otherwise the buffer becomes invalid.
  - No read, buffer empty, write: SRAM writes i_wr_addr/i_wr_data directly; buffer stays empty.
- Forwarding:
  - If wb_vld & wb_addr==i_rd_addr at read time, the response returns wb_data instead of SRAM dout. The forward select is registered alongside the response.
  - Same-cycle read and write to the same address is read-first: the response is the value before that write.
- Consecutive writes to the same address: the last write wins; buffer drain ordering preserves program order.
- o_rd_data holds its last value when o_rd_vld=0.
- rst mid-operation:
  - Buffer contents are discarded (not drained).
  - An in-flight read response is dropped (o_rd_vld=0 next cycle).
  - INIT restarts from cnt=0.
- No X on outputs after reset.
- Address width is exactly A; no wrap logic is needed beyond the counter terminating at N-1.

Test Plan:
- Init: N=16, assert rst 2 cycles -> o_busy=1 for exactly 16 cycles after deassert, then 0; reads of addr 0..15 all return INIT_VAL=0.
- Write then read: write addr 3 = 10'h2A (no read), next cycle read 3 -> o_rd_vld next cycle, o_rd_data=10'h2A.
- Forwarding: write addr 5 = 10'h155 with a simultaneous read of addr 9 (buffered). Next cycle read addr 5 -> response 10'h155 from the buffer. Same-cycle read/write of addr 7 (old 0, new 10'h3FF) -> response 0, and a later read returns 10'h3FF.
- Backpressure: buffer full and i_rd_vld=1 -> o_wr_rdy=0 and the write is held. Read drops the next cycle -> buffer drains, the new write is accepted, and the final contents match the reference model.
- Reset mid-op: buffer holds addr 2 = 10'h11 and a read is in flight, then assert rst -> o_rd_vld=0, re-init completes, and read 2 returns INIT_VAL.
- Random: 10k cycles of random rd/wr (N=64, W=10) against a scoreboard -> zero mismatches, and no o_rd_vld while o_busy.
